// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared definitions for the spi_core transfer sequencer.
// Contents: spi_core register offsets, CTRL bit positions, sequencer FSM
// state enum and a helper that assembles the CTRL word for a transfer.
package spi_seq_pkg;

  // spi_core register offsets (RX0 and TX0 share an address)
  localparam logic [7:0] REG_RX0     = 8'h00;
  localparam logic [7:0] REG_TX0     = 8'h00;
  localparam logic [7:0] REG_CTRL    = 8'h10;
  localparam logic [7:0] REG_DIVIDER = 8'h14;
  localparam logic [7:0] REG_SS      = 8'h18;

  // CTRL register bit positions
  localparam int CTRL_GO_BIT  = 8;
  localparam int CTRL_LSB_BIT = 11;
  localparam int CTRL_IE_BIT  = 12;
  localparam int CTRL_ASS_BIT = 13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DIV  = 3'd1,
    ST_WR_SS   = 3'd2,
    ST_WR_TX   = 3'd3,
    ST_WR_CTRL = 3'd4,
    ST_WAIT    = 3'd5,
    ST_RD_RX   = 3'd6,
    ST_RESP    = 3'd7
  } seq_state_e;

  // CTRL = GO | ASS | IE | (lsb << LSB) | len ; len 0 encodes 128 bits in spi_core
  function automatic logic [31:0] ctrl_word(input logic [6:0] len, input logic lsb);
    logic [31:0] w;
    w                = 32'(len);
    w[CTRL_GO_BIT]   = 1'b1;
    w[CTRL_ASS_BIT]  = 1'b1;
    w[CTRL_IE_BIT]   = 1'b1;
    w[CTRL_LSB_BIT]  = lsb;
    return w;
  endfunction

endpackage

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: runs one spi_core transfer per request (DIVIDER, SS, TX0, CTRL
// writes, wait for interrupt, RX0 read) and returns the RX word with an error flag.
// Ports: clk_i/rst_i (async active-high); req_* valid/ready request; rsp_* one-cycle
// response pulse; reg_* register master to spi_core; spi_intr_i completion interrupt.
// Optional: define SPI_SEQ_TIMEOUT_EN to abort the wait after TIMEOUT_CYC cycles.
module spi_xfer_seq
  import spi_seq_pkg::*;
#(
  parameter logic [15:0] CLK_DIV     = 16'd4,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_ss_i,
  input  logic [6:0]  req_len_i,
  input  logic        req_lsb_i,
  input  logic [31:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        reg_we_o,
  output logic        reg_re_o,
  output logic [7:0]  reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_be_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_err_i,
  input  logic        spi_intr_i
);

  // Elaboration-time guard on the timeout length
  if (TIMEOUT_CYC < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  seq_state_e  state_q, state_d;
  logic [7:0]  ss_q, ss_d;
  logic [6:0]  len_q, len_d;
  logic        lsb_q, lsb_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        acc;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    ss_d       = ss_q;
    len_d      = len_q;
    lsb_d      = lsb_q;
    data_d     = data_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    acc        = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    tmo_d      = '0;
`endif
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    reg_we_o    = 1'b0;
    reg_re_o    = 1'b0;
    reg_addr_o  = 8'h00;
    reg_wdata_o = 32'h0;
    reg_be_o    = 4'h0;

    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          ss_d    = req_ss_i;
          len_d   = req_len_i;
          lsb_d   = req_lsb_i;
          data_d  = req_data_i;
          err_d   = 1'b0;
          state_d = ST_WR_DIV;
        end
      end
      ST_WR_DIV: begin
        acc         = 1'b1;
        reg_we_o    = 1'b1;
        reg_be_o    = 4'hF;
        reg_addr_o  = REG_DIVIDER;
        reg_wdata_o = {16'h0, CLK_DIV};
        state_d     = ST_WR_SS;
      end
      ST_WR_SS: begin
        acc         = 1'b1;
        reg_we_o    = 1'b1;
        reg_be_o    = 4'hF;
        reg_addr_o  = REG_SS;
        reg_wdata_o = {24'h0, ss_q};
        state_d     = ST_WR_TX;
      end
      ST_WR_TX: begin
        acc         = 1'b1;
        reg_we_o    = 1'b1;
        reg_be_o    = 4'hF;
        reg_addr_o  = REG_TX0;
        reg_wdata_o = data_q;
        state_d     = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        acc         = 1'b1;
        reg_we_o    = 1'b1;
        reg_be_o    = 4'hF;
        reg_addr_o  = REG_CTRL;
        reg_wdata_o = ctrl_word(len_q, lsb_q);
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // Interrupt wins over a timeout that expires in the same cycle
        if (spi_intr_i) begin
          state_d = ST_RD_RX;
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          err_d      = 1'b1;
          rsp_data_d = 32'h0;
          state_d    = ST_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      ST_RD_RX: begin
        acc        = 1'b1;
        reg_re_o   = 1'b1;
        reg_addr_o = REG_RX0;
        rsp_data_d = reg_rdata_i;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Sticky: any access error during this transfer is reported in RESP
    if (acc && reg_err_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ss_q       <= 8'h0;
      len_q      <= 7'h0;
      lsb_q      <= 1'b0;
      data_q     <= 32'h0;
      err_q      <= 1'b0;
      rsp_data_q <= 32'h0;
`ifdef SPI_SEQ_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ss_q       <= ss_d;
      len_q      <= len_d;
      lsb_q      <= lsb_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
`ifdef SPI_SEQ_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign rsp_data_o = rsp_data_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: directed, table-driven bench for spi_xfer_seq.
// Drives requests and a simple spi_core model by hand, checks every register
// access, the response, reset behaviour and back-to-back handshakes.
module tb_spi_xfer_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [7:0]  req_ss_i = 8'h0;
  logic [6:0]  req_len_i = 7'h0;
  logic        req_lsb_i = 1'b0;
  logic [31:0] req_data_i = 32'h0;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        reg_we_o;
  logic        reg_re_o;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_be_o;
  logic [31:0] reg_rdata_i = 32'h0;
  logic        reg_err_i = 1'b0;
  logic        spi_intr_i = 1'b0;

  int errs   = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  spi_xfer_seq #(.CLK_DIV(16'd4), .TIMEOUT_CYC(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_ss_i    (req_ss_i),
    .req_len_i   (req_len_i),
    .req_lsb_i   (req_lsb_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_be_o    (reg_be_o),
    .reg_rdata_i (reg_rdata_i),
    .reg_err_i   (reg_err_i),
    .spi_intr_i  (spi_intr_i)
  );

  typedef struct {
    logic [7:0]  ss;
    logic [6:0]  len;
    logic        lsb;
    logic [31:0] data;
    logic [31:0] rx;
    int          wait_n;   // extra WAIT cycles before the interrupt
    bit          early;    // raise the interrupt already during the write phase
    int          err_k;    // access index (0..3 writes, 4 read) given reg_err_i; 9 = none
    logic [31:0] exp_ctrl;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; return once the handshake posedge has passed
  task automatic send_req(input vec_t v, input bit keep_valid, output int waited);
    waited      = 0;
    req_ss_i    = v.ss;
    req_len_i   = v.len;
    req_lsb_i   = v.lsb;
    req_data_i  = v.data;
    req_valid_i = 1'b1;
    while (!req_ready_o && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    chk("accept_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    if (!keep_valid) req_valid_i = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v, input bit keep_valid, input bit expect_imm);
    int waited;
    logic [7:0]  ea [4];
    logic [31:0] ed [4];
    ea = '{8'h14, 8'h18, 8'h00, 8'h10};
    ed = '{32'd4, {24'h0, v.ss}, v.data, v.exp_ctrl};
    send_req(v, keep_valid, waited);
    if (expect_imm) chk("b2b_accept_delay", 32'(waited), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("wr_strobes", 32'({reg_we_o, reg_re_o, reg_be_o}), 32'h2F);
      chk("wr_addr", 32'(reg_addr_o), 32'(ea[k]));
      chk("wr_data", reg_wdata_o, ed[k]);
      chk("busy_ready", 32'(req_ready_o), 32'd0);
      reg_err_i = (v.err_k == k);
      if (v.early && k == 0) begin
        spi_intr_i  = 1'b1;
        reg_rdata_i = v.rx;
      end
    end
    for (int i = 0; i <= v.wait_n; i++) begin
      @(negedge clk_i);
      reg_err_i = 1'b0;
      chk("wait_quiet", 32'({rsp_valid_o, reg_we_o, reg_re_o, req_ready_o}), 32'd0);
      if (i == 0) chk("wait_bus", reg_wdata_o | 32'(reg_addr_o) | 32'(reg_be_o), 32'd0);
      if (i == v.wait_n) begin
        spi_intr_i  = 1'b1;
        reg_rdata_i = v.rx;
      end
    end
    @(negedge clk_i);
    chk("rd_strobes", 32'({reg_we_o, reg_re_o}), 32'd1);
    chk("rd_addr", 32'(reg_addr_o), 32'h00);
    spi_intr_i = 1'b0;
    reg_err_i  = (v.err_k == 4);
    @(negedge clk_i);
    reg_err_i   = 1'b0;
    reg_rdata_i = ~v.rx;
    chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("rsp_data", rsp_data_o, v.rx);
    chk("rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
    @(negedge clk_i);
    chk("rsp_pulse_end", 32'(rsp_valid_o), 32'd0);
    chk("rsp_data_hold", rsp_data_o, v.rx);
    chk("idle_ready", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    int w;
    bit saw;
    //          ss     len    lsb   data           rx             wait early err exp_ctrl       exp_err
    vecs[0] = '{8'h01, 7'd8,  1'b0, 32'h0000_00A5, 32'h0000_005A, 14, 1'b0, 9, 32'h0000_3108, 1'b0};
    vecs[1] = '{8'h80, 7'd0,  1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 2,  1'b0, 9, 32'h0000_3900, 1'b0};
    vecs[2] = '{8'h04, 7'd32, 1'b0, 32'h0F0F_0F0F, 32'hCAFE_F00D, 3,  1'b0, 1, 32'h0000_3120, 1'b1};
    vecs[3] = '{8'hFF, 7'h7F, 1'b1, 32'h8000_0001, 32'h5555_AAAA, 0,  1'b1, 9, 32'h0000_397F, 1'b0};
    vecs[4] = '{8'h02, 7'd16, 1'b0, 32'h0000_FFFF, 32'h0BAD_C0DE, 1,  1'b0, 4, 32'h0000_3110, 1'b1};
    vecs[5] = '{8'h10, 7'd1,  1'b1, 32'h1111_2222, 32'h3333_4444, 0,  1'b0, 9, 32'h0000_3901, 1'b0};
    vecs[6] = '{8'h20, 7'd64, 1'b0, 32'h7777_8888, 32'h9999_AAAA, 1,  1'b0, 9, 32'h0000_3140, 1'b0};

    // Reset state
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp", 32'({rsp_valid_o, rsp_err_o}), 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    chk("rst_strobes", 32'({reg_we_o, reg_re_o, reg_be_o, reg_addr_o}), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Table-driven single transfers
    for (int n = 0; n < 5; n++) run_xfer(vecs[n], 1'b0, 1'b0);

    // Back-to-back with req_valid_i held high
    run_xfer(vecs[5], 1'b1, 1'b0);
    run_xfer(vecs[6], 1'b0, 1'b1);

`ifdef SPI_SEQ_TIMEOUT_EN
    // No interrupt: 4 write cycles + 16 WAIT cycles, then RESP without a read
    send_req(vecs[0], 1'b0, w);
    w   = 0;
    saw = 1'b0;
    while (!rsp_valid_o && w < 100) begin
      @(negedge clk_i);
      if (reg_re_o) saw = 1'b1;
      if (!rsp_valid_o) w++;
    end
    chk("tmo_cycles", 32'(w), 32'd20);
    chk("tmo_no_read", 32'(saw), 32'd0);
    chk("tmo_err", 32'(rsp_err_o), 32'd1);
    chk("tmo_data", rsp_data_o, 32'd0);
    @(negedge clk_i);
`endif

    // Reset in the middle of WAIT: no response afterwards
    send_req(vecs[1], 1'b0, w);
    repeat (6) @(negedge clk_i);
    chk("pre_rst_busy", 32'(req_ready_o), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready_o), 32'd1);
    chk("midrst_strobes", 32'({reg_we_o, reg_re_o, reg_be_o, reg_addr_o}), 32'd0);
    chk("midrst_rsp", 32'({rsp_valid_o, rsp_err_o}), 32'd0);
    chk("midrst_rsp_data", rsp_data_o, 32'd0);
    @(negedge clk_i);
    rst_i      = 1'b0;
    spi_intr_i = 1'b1;
    saw        = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o || reg_re_o || reg_we_o || !req_ready_o) saw = 1'b1;
    end
    spi_intr_i = 1'b0;
    chk("aborted_no_rsp", 32'(saw), 32'd0);

    // Normal transfer still works after the abort
    run_xfer(vecs[0], 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
